fetch_decode_stage: RTL and testbench

- Instruction fetch and decode stage directly upstream of the register file.
- Holds the PC, fetches 32-bit words over a request/valid instruction-memory interface, and decodes the ARM-subset fields.
- Produces RA1/RA2/RA3, the 2-bit RegWrite code, PCPlus4/PCPlus8 and the immediate.
- Hands results downstream with a valid/ready handshake and accepts branch redirects from execute.

---
 rtl/fetch_decode_stage.sv | 139 +++++++++++++
 tb/tb_fetch_decode_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC, instruction fetch over req/valid, ARM-subset decode, valid/ready output.
// Optional backpressure counter STALL_CNT enabled by defining FD_STALL_CNT_EN.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  output logic                   IMEM_REQ,
  output logic [31:0]            IMEM_ADDR,
  input  logic                   IMEM_VALID,
  input  logic [31:0]            IMEM_RDATA,
  input  logic                   BR_TAKEN,
  input  logic [31:0]            BR_TARGET,
  input  logic                   OUT_READY,
  output logic                   OUT_VALID,
  output logic [31:0]            INSTR,
  output logic [3:0]             RA1,
  output logic [3:0]             RA2,
  output logic [3:0]             RA3,
  output logic [1:0]             RegWrite,
  output logic [31:0]            PCPlus4,
  output logic [31:0]            PCPlus8,
  output logic [31:0]            IMM,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);
  typedef enum logic [1:0] {FETCH, VALID, DROP} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, p4_q, p8_q, imm_q, imm_d;
  logic [3:0]  ra1_q, ra2_q, ra3_q, ra1_d, ra2_d, ra3_d;
  logic [1:0]  rw_q, rw_d;
  logic        req_q, load;
  logic [31:0] d;

  assign d = IMEM_RDATA;

  always_comb begin
    ra1_d = '0;
    ra2_d = '0;
    ra3_d = '0;
    rw_d  = 2'b10;
    imm_d = '0;
    case (d[27:26])
      2'b00: begin
        ra1_d = d[19:16];
        ra2_d = d[3:0];
        ra3_d = d[15:12];
        rw_d  = (d[24:21] == 4'b1010) ? 2'b10 : 2'b11;
        imm_d = {24'b0, d[7:0]};
      end
      2'b01: begin
        ra1_d = d[19:16];
        ra2_d = d[20] ? 4'b0 : d[15:12];
        ra3_d = d[20] ? d[15:12] : 4'b0;
        rw_d  = d[20] ? 2'b11 : 2'b10;
        imm_d = {20'b0, d[11:0]};
      end
      2'b10: begin
        rw_d  = {1'b0, d[24]};
        imm_d = {{6{d[23]}}, d[23:0], 2'b00};
      end
      default: ;
    endcase
  end

  // A redirect while a request is in flight must swallow its response in DROP.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    case (state_q)
      FETCH: if (req_q && IMEM_VALID) begin
        load    = !BR_TAKEN;
        pc_d    = pc_q + 32'd4;
        state_d = VALID;
      end
      VALID:   state_d = OUT_READY ? FETCH : VALID;
      DROP:    state_d = IMEM_VALID ? FETCH : DROP;
      default: state_d = FETCH;
    endcase
    if (BR_TAKEN) begin
      pc_d    = {BR_TARGET[31:2], 2'b00};
      state_d = (!IMEM_VALID && ((state_q == FETCH && req_q) || state_q == DROP)) ? DROP : FETCH;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      ra3_q   <= '0;
      rw_q    <= 2'b10;
      imm_q   <= '0;
      p4_q    <= '0;
      p8_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == FETCH);
      if (load) begin
        instr_q <= IMEM_RDATA;
        ra1_q   <= ra1_d;
        ra2_q   <= ra2_d;
        ra3_q   <= ra3_d;
        rw_q    <= rw_d;
        imm_q   <= imm_d;
        p4_q    <= pc_q + 32'd4;
        p8_q    <= pc_q + 32'd8;
      end
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign OUT_VALID = (state_q == VALID);
  assign INSTR     = instr_q;
  assign RA1       = ra1_q;
  assign RA2       = ra2_q;
  assign RA3       = ra3_q;
  assign RegWrite  = rw_q;
  assign PCPlus4   = p4_q;
  assign PCPlus8   = p8_q;
  assign IMM       = imm_q;

`ifdef FD_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) stall_q <= '0;
    else if (state_q == VALID && !OUT_READY && !(&stall_q)) stall_q <= stall_q + STALL_CNT_W'(1);
  end
  assign STALL_CNT = stall_q;
`else
  assign STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed checks of fetch, decode, redirect, wraparound and async reset.
module tb_fetch_decode_stage;
  logic        clk = 0, rst_n;
  logic        valid, valid2, br, ready, ready2;
  logic [31:0] rdata, brt;
  logic        req, req2, ov, ov2;
  logic [31:0] addr, addr2, instr, instr2, p4, p4_2, p8, p8_2, imm, imm2;
  logic [3:0]  ra1, ra2, ra3, ra1_2, ra2_2, ra3_2;
  logic [1:0]  rw, rw2;
  logic [15:0] sc, sc2;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .CLK(clk), .RESETn(rst_n), .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_VALID(valid),
    .IMEM_RDATA(rdata), .BR_TAKEN(br), .BR_TARGET(brt), .OUT_READY(ready), .OUT_VALID(ov),
    .INSTR(instr), .RA1(ra1), .RA2(ra2), .RA3(ra3), .RegWrite(rw), .PCPlus4(p4),
    .PCPlus8(p8), .IMM(imm), .STALL_CNT(sc));

  fetch_decode_stage #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .CLK(clk), .RESETn(rst_n), .IMEM_REQ(req2), .IMEM_ADDR(addr2), .IMEM_VALID(valid2),
    .IMEM_RDATA(rdata), .BR_TAKEN(1'b0), .BR_TARGET(32'h0), .OUT_READY(ready2), .OUT_VALID(ov2),
    .INSTR(instr2), .RA1(ra1_2), .RA2(ra2_2), .RA3(ra3_2), .RegWrite(rw2), .PCPlus4(p4_2),
    .PCPlus8(p8_2), .IMM(imm2), .STALL_CNT(sc2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    int n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    check("req_wait", {31'b0, req}, 32'd1);
    tick();
    valid = 1;
    rdata = w;
    tick();
    valid = 0;
  endtask

  initial begin
    valid = 0; valid2 = 0; br = 0; brt = 0; ready = 0; ready2 = 1; rdata = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check("rst_ov", {31'b0, ov}, 32'd0);
    check("rst_rw", {30'b0, rw}, 32'd2);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_p4", p4, 32'd0);
    check("rst_imm", imm, 32'd0);
    check("rst_sc", {16'b0, sc}, 32'd0);
    tick(); tick();
    rst_n = 1;
    tick();
    check("req_after_rst", {31'b0, req}, 32'd1);
    check("addr_after_rst", addr, 32'd0);
    check("wrap_addr", addr2, 32'hFFFFFFFC);
    // wraparound instance: one fetch from 0xFFFFFFFC
    tick();
    valid2 = 1;
    rdata = 32'hE0821003;
    tick();
    valid2 = 0;
    check("wrap_ov", {31'b0, ov2}, 32'd1);
    check("wrap_p4", p4_2, 32'd0);
    check("wrap_p8", p8_2, 32'd4);
    tick();
    check("wrap_next_addr", addr2, 32'd0);
    check("wrap_next_req", {31'b0, req2}, 32'd1);
    // ADD R1,R2,R3 with 5 cycles of backpressure
    fetch(32'hE0821003);
    check("add_ov", {31'b0, ov}, 32'd1);
    check("add_ra1", {28'b0, ra1}, 32'd2);
    check("add_ra2", {28'b0, ra2}, 32'd3);
    check("add_ra3", {28'b0, ra3}, 32'd1);
    check("add_rw", {30'b0, rw}, 32'd3);
    check("add_p4", p4, 32'd4);
    check("add_p8", p8, 32'd8);
    check("add_imm", imm, 32'd3);
    check("add_req_low", {31'b0, req}, 32'd0);
    repeat (5) tick();
    check("stall_ov", {31'b0, ov}, 32'd1);
    check("stall_instr", instr, 32'hE0821003);
    check("stall_ra1", {28'b0, ra1}, 32'd2);
`ifdef FD_STALL_CNT_EN
    check("stall_cnt", {16'b0, sc}, 32'd5);
`else
    check("stall_cnt", {16'b0, sc}, 32'd0);
`endif
    ready = 1;
    tick();
    check("rel_ov", {31'b0, ov}, 32'd0);
    check("rel_req", {31'b0, req}, 32'd1);
    check("rel_addr", addr, 32'd4);
    // redirect before response: drop the in-flight word
    br = 1; brt = 32'h103;
    tick();
    br = 0;
    check("drop_req", {31'b0, req}, 32'd0);
    check("drop_ov", {31'b0, ov}, 32'd0);
    tick();
    check("drop_req_hold", {31'b0, req}, 32'd0);
    valid = 1; rdata = 32'hE0821003;
    tick();
    valid = 0;
    check("drop_no_ov", {31'b0, ov}, 32'd0);
    check("drop_req_back", {31'b0, req}, 32'd1);
    check("drop_addr", addr, 32'h100);
    // redirect coinciding with response: word discarded
    br = 1; brt = 32'h10; valid = 1;
    tick();
    br = 0; valid = 0;
    check("brv_ov", {31'b0, ov}, 32'd0);
    check("brv_addr", addr, 32'h10);
    fetch(32'hEB000002);
    check("bl_rw", {30'b0, rw}, 32'd1);
    check("bl_imm", imm, 32'd8);
    check("bl_p4", p4, 32'h14);
    check("bl_p8", p8, 32'h18);
    check("bl_ra1", {28'b0, ra1}, 32'd0);
    check("bl_ra3", {28'b0, ra3}, 32'd0);
    tick();
    check("bl_next_addr", addr, 32'h14);
    fetch(32'hEA000002);
    check("b_rw", {30'b0, rw}, 32'd0);
    tick();
    fetch(32'hEAFFFFFE);
    check("bneg_imm", imm, 32'hFFFFFFF8);
    tick();
    fetch(32'hE1530004);
    check("cmp_rw", {30'b0, rw}, 32'd2);
    check("cmp_ra1", {28'b0, ra1}, 32'd3);
    check("cmp_ra2", {28'b0, ra2}, 32'd4);
    tick();
    fetch(32'hE5912004);
    check("ldr_rw", {30'b0, rw}, 32'd3);
    check("ldr_ra1", {28'b0, ra1}, 32'd1);
    check("ldr_ra2", {28'b0, ra2}, 32'd0);
    check("ldr_ra3", {28'b0, ra3}, 32'd2);
    check("ldr_imm", imm, 32'd4);
    tick();
    fetch(32'hE5812004);
    check("str_rw", {30'b0, rw}, 32'd2);
    check("str_ra2", {28'b0, ra2}, 32'd2);
    check("str_ra3", {28'b0, ra3}, 32'd0);
    tick();
    fetch(32'hEC000000);
    check("nop_rw", {30'b0, rw}, 32'd2);
    check("nop_imm", imm, 32'd0);
    check("nop_ra1", {28'b0, ra1}, 32'd0);
    check("nop_ov", {31'b0, ov}, 32'd1);
    // asynchronous reset between edges
    #3 rst_n = 0;
    #1;
    check("arst_ov", {31'b0, ov}, 32'd0);
    check("arst_rw", {30'b0, rw}, 32'd2);
    check("arst_req", {31'b0, req}, 32'd0);
    check("arst_instr", instr, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
